// File: rtl/ifmap_spad.sv
// ---------------------------------------------------------------------------
// ifmap_spad
// Input-feature-map scratchpad for one PE. It holds DEPTH words of
// DATA_WIDTH bits in a single-port synchronous register array, with one
// access per cycle.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   rst        synchronous, active-high reset; clears mem and rdata,
//              and takes priority over a write
//   addr       entry index for this cycle's write or read
//   we         1 = write cycle (external agent drives data_port)
//              0 = read cycle  (spad drives data_port with rdata)
//   data_port  shared bidirectional data bus
//
// A read has one cycle of latency. The address presented before edge N
// appears on data_port after edge N. DEPTH must equal 2**ADDR_WIDTH, so
// every addr value is a valid entry.
// ---------------------------------------------------------------------------
module ifmap_spad #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  we,
   inout  wire  [DATA_WIDTH-1:0] data_port
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata;

   // Storage update. Reset clears everything. Otherwise the cycle is
   // either a write (rdata holds) or a read (rdata captures the entry).
   always_ff @(posedge clk) begin
      if (rst) begin
         mem   <= '{default: '0};
         rdata <= '0;
      end else if (we) begin
         mem[addr] <= data_port;
      end else begin
         rdata <= mem[addr];
      end
   end

   // Bus drive depends only on we. The spad releases the bus in the same
   // delta that we rises, so it never contends with the external writer.
   assign data_port = we ? {DATA_WIDTH{1'bz}} : rdata;

endmodule

// File: tb/tb_ifmap_spad.sv
// ---------------------------------------------------------------------------
// tb_ifmap_spad
// Self-checking bench for ifmap_spad. A behavioural scratchpad model
// (array plus last-read word) supplies every expected value.
// ---------------------------------------------------------------------------
module tb_ifmap_spad;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned N  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addr;
   logic          we;
   logic          drv_en;
   logic [DW-1:0] drv_data;
   wire  [DW-1:0] data_port;

   // Behavioural model: contents and the word last returned by a read.
   logic [DW-1:0] ref_mem [N];
   logic [DW-1:0] exp_rdata;

   int checks = 0;
   int errors = 0;

   assign data_port = drv_en ? drv_data : {DW{1'bz}};

   always #5 clk = ~clk;

   ifmap_spad #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .we        (we),
      .data_port (data_port)
   );

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic do_reset(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rst = 1'b1; we = wr; drv_en = wr; addr = a; drv_data = d;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < int'(N); i++) ref_mem[i] = '0;
      exp_rdata = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      we = 1'b1; drv_en = 1'b1; addr = a; drv_data = d;
      cyc();
      ref_mem[a] = d;
   endtask

   task automatic rd(input logic [AW-1:0] a, input string tag);
      we = 1'b0; drv_en = 1'b0; addr = a;
      cyc();
      exp_rdata = ref_mem[a];
      chk($sformatf("%s[%0d]", tag, a), data_port, exp_rdata);
   endtask

   initial begin
      int order [N];
      int j;
      int tmp;

      rst = 1'b0; we = 1'b0; drv_en = 1'b0; addr = '0; drv_data = '0;

      // A single reset cycle, then read back every entry as zero.
      do_reset(1'b0, '0, '0);
      chk("reset_bus", data_port, 16'h0000);
      for (int i = 0; i < int'(N); i++) rd(AW'(i), "reset_sweep");

      // Sequential fill, then a readback sweep.
      for (int i = 0; i < int'(N); i++) wr(AW'(i), 16'hA500 + DW'(i));
      for (int i = 0; i < int'(N); i++) rd(AW'(i), "fill_sweep");

      // Bus turnaround: the spad releases while we=1, and drives rdata
      // again as soon as we falls, with no clock edge in between.
      we = 1'b1; drv_en = 1'b1; drv_data = 16'h1234; addr = 4'd9;
      #1;
      chk("turn_we1", data_port, 16'h1234);
      we = 1'b0; drv_en = 1'b0;
      #1;
      chk("turn_we0", data_port, exp_rdata);
      cyc();
      exp_rdata = ref_mem[9];
      chk("turn_read9", data_port, exp_rdata);

      // A write cycle must leave rdata untouched.
      rd(4'd2, "pre_hold");
      wr(4'd5, 16'h5A5A);
      we = 1'b0; drv_en = 1'b0;
      #1;
      chk("rdata_hold", data_port, exp_rdata);

      // Overwrite and isolation.
      wr(4'd7, 16'hFFFF);
      wr(4'd7, 16'h0001);
      rd(4'd6, "iso");
      rd(4'd7, "iso");
      rd(4'd8, "iso");
      rd(4'd5, "iso");

      // Reset wins over a simultaneous write.
      do_reset(1'b1, 4'd3, 16'hBEEF);
      we = 1'b0; drv_en = 1'b0;
      #1;
      chk("rst_prio_bus", data_port, 16'h0000);
      rd(4'd3, "rst_prio");
      rd(4'd0, "rst_prio");

      // Random writes at ascending addresses, then a shuffled readback.
      for (int i = 0; i < int'(N); i++) wr(AW'(i), DW'($urandom));
      for (int i = 0; i < int'(N); i++) order[i] = i;
      for (int i = int'(N) - 1; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < int'(N); i++) rd(AW'(order[i]), "rand");

      // Back-to-back write then read of the same entry.
      wr(4'd12, DW'($urandom));
      rd(4'd12, "wr_then_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
